store_drain_unit: RTL and testbench

//  Drains retired stores from the store buffer head into the data memory port. It sits between
//  the store buffer (head_valid/head_addr/head_data, pop_head) and the L1-D / memory write port.
//  A small in-order write buffer decouples store-buffer pops from memory latency.

---
 rtl/sd_pkg.sv | 19 +
 rtl/store_drain_unit_if.sv | 27 ++
 rtl/sd_wbuf.sv | 79 +++++++
 rtl/store_drain_unit.sv | 83 ++++++++
 tb/tb_store_drain_unit.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/sd_pkg.sv
// Shared types, default widths and pointer-width helper for the store drain unit.
package sd_pkg;

  typedef enum logic {
    SD_IDLE  = 1'b0,
    SD_ISSUE = 1'b1
  } sd_state_e;

  localparam int unsigned SD_ADDR_W   = 16;
  localparam int unsigned SD_DATA_W   = 16;
  localparam int unsigned SD_WB_DEPTH = 4;
  localparam int unsigned SD_CNT_W    = 16;

  // One extra pointer bit distinguishes full from empty.
  function automatic int unsigned wb_ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/store_drain_unit_if.sv
// Store-buffer head, memory write port and load-snoop signals of the store drain unit.
interface store_drain_unit_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              head_valid;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              pop_head;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [ADDR_W-1:0] ld_search_addr;
  logic              ld_match;
  logic [DATA_W-1:0] ld_data;

  modport slave (
    input  head_valid, head_addr, head_data, mem_ack, ld_search_addr,
    output pop_head, mem_req, mem_addr, mem_wdata, ld_match, ld_data
  );

  modport master (
    output head_valid, head_addr, head_data, mem_ack, ld_search_addr,
    input  pop_head, mem_req, mem_addr, mem_wdata, ld_match, ld_data
  );
endinterface

// File: rtl/sd_wbuf.sv
// In-order write buffer: entry storage, read/write pointers, full/empty flags and
// youngest-first address snoop.
module sd_wbuf
  import sd_pkg::*;
#(
  parameter int unsigned ADDR_W = SD_ADDR_W,
  parameter int unsigned DATA_W = SD_DATA_W,
  parameter int unsigned DEPTH  = SD_WB_DEPTH
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              wr_en,
  input  logic              comb_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] search_addr,
  output logic              full,
  output logic              empty,
  output logic              single,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] young_addr,
  output logic              young_is_rd,
  output logic              match,
  output logic [DATA_W-1:0] match_data
);
  localparam int unsigned PTR_W = wb_ptr_w(DEPTH);
  localparam int unsigned IDX_W = PTR_W - 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, young_ptr, occ, scan_ptr;

  assign young_ptr   = wr_ptr - PTR_W'(1);
  assign occ         = wr_ptr - rd_ptr;
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                       (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign single      = (occ == PTR_W'(1));
  assign rd_addr     = addr_q[rd_ptr[IDX_W-1:0]];
  assign rd_data     = data_q[rd_ptr[IDX_W-1:0]];
  assign young_addr  = addr_q[young_ptr[IDX_W-1:0]];
  assign young_is_rd = (young_ptr == rd_ptr);

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        addr_q[wr_ptr[IDX_W-1:0]] <= wr_addr;
        data_q[wr_ptr[IDX_W-1:0]] <= wr_data;
        wr_ptr <= wr_ptr + PTR_W'(1);
      end else if (comb_en) begin
        data_q[young_ptr[IDX_W-1:0]] <= wr_data;
      end
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Scan oldest to youngest so the last hit, i.e. the youngest match, wins.
  always_comb begin
    match      = 1'b0;
    match_data = '0;
    scan_ptr   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_ptr = rd_ptr + PTR_W'(i);
      if ((PTR_W'(i) < occ) && (addr_q[scan_ptr[IDX_W-1:0]] == search_addr)) begin
        match      = 1'b1;
        match_data = data_q[scan_ptr[IDX_W-1:0]];
      end
    end
  end
endmodule

// File: rtl/store_drain_unit.sv
// Drains retired stores through a small write buffer into the memory write port.
// Optional feature macro: WRITE_COMBINE_EN (same-address merge into the youngest idle entry).
module store_drain_unit
  import sd_pkg::*;
#(
  parameter int unsigned ADDR_W   = SD_ADDR_W,
  parameter int unsigned DATA_W   = SD_DATA_W,
  parameter int unsigned WB_DEPTH = SD_WB_DEPTH,
  parameter int unsigned CNT_W    = SD_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  store_drain_unit_if.slave bus,
  output logic             drained,
  output logic [CNT_W-1:0] drain_count
);
`ifdef WRITE_COMBINE_EN
  localparam bit COMBINE = 1'b1;
`else
  localparam bit COMBINE = 1'b0;
`endif

  sd_state_e         state, state_n;
  logic              full, empty, single, young_is_rd;
  logic              comb_hit, pop, wr_en, comb_en, ack;
  logic [ADDR_W-1:0] young_addr;

  // Never merge into the entry currently presented on the memory port.
  assign comb_hit = COMBINE && !empty && (bus.head_addr == young_addr) &&
                    !((state == SD_ISSUE) && young_is_rd);
  assign pop      = bus.head_valid && (comb_hit || !full);
  assign wr_en    = pop && !comb_hit;
  assign comb_en  = pop && comb_hit;
  assign ack      = (state == SD_ISSUE) && bus.mem_ack;

  assign bus.pop_head = pop;
  assign bus.mem_req  = (state == SD_ISSUE);
  assign drained      = empty && (state == SD_IDLE);

  sd_wbuf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (WB_DEPTH)
  ) u_wbuf (
    .CLK         (CLK),
    .RST         (RST),
    .wr_en       (wr_en),
    .comb_en     (comb_en),
    .wr_addr     (bus.head_addr),
    .wr_data     (bus.head_data),
    .rd_en       (ack),
    .search_addr (bus.ld_search_addr),
    .full        (full),
    .empty       (empty),
    .single      (single),
    .rd_addr     (bus.mem_addr),
    .rd_data     (bus.mem_wdata),
    .young_addr  (young_addr),
    .young_is_rd (young_is_rd),
    .match       (bus.ld_match),
    .match_data  (bus.ld_data)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= SD_IDLE;
    else     state <= state_n;
  end

  // An enqueue at this edge already counts as pending, so a request follows the pop directly.
  always_comb begin
    state_n = state;
    unique case (state)
      SD_IDLE:  if (!empty || wr_en) state_n = SD_ISSUE;
      SD_ISSUE: if (ack && single && !wr_en) state_n = SD_IDLE;
      default:  state_n = SD_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST)      drain_count <= '0;
    else if (ack) drain_count <= drain_count + CNT_W'(1);
  end
endmodule

// File: tb/tb_store_drain_unit.sv
// Directed bench for store_drain_unit; expected memory writes are queued by stimulus
// and checked by an independent monitor.
module tb_store_drain_unit;
  logic        CLK = 1'b0;
  logic        RST;
  logic        drained;
  logic [15:0] drain_count;

  store_drain_unit_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  store_drain_unit #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .WB_DEPTH (4),
    .CNT_W    (16)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .bus         (bus),
    .drained     (drained),
    .drain_count (drain_count)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  wr_cnt = 0;
  int  exp_drain = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Sampled on the falling edge: a request with ack here completes at the next rising edge.
  always @(negedge CLK) begin
    if (!RST && bus.mem_req && bus.mem_ack) begin
      wr_t e;
      wr_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got 0x%0h/0x%0h, expected none", bus.mem_addr, bus.mem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.mem_addr), 32'(e.a));
        chk("wr_data", 32'(bus.mem_wdata), 32'(e.d));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic expect_wr(input logic [15:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
    exp_drain++;
  endtask

  task automatic enq(input logic [15:0] a, input logic [15:0] d, input string name);
    bus.head_valid = 1'b1;
    bus.head_addr  = a;
    bus.head_data  = d;
    #1;
    chk(name, 32'(bus.pop_head), 32'd1);
    step(1);
    bus.head_valid = 1'b0;
  endtask

  task automatic drain_all(input string name);
    int k;
    k = 0;
    bus.mem_ack = 1'b1;
    while (!drained && k < 40) begin
      step(1);
      k++;
    end
    bus.mem_ack = 1'b0;
    #1;
    chk({name, "_drained"}, 32'(drained), 32'd1);
    chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_count"}, 32'(drain_count), 32'(exp_drain));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, w0;
    RST = 1'b1;
    bus.head_valid = 1'b0;
    bus.head_addr = '0;
    bus.head_data = '0;
    bus.mem_ack = 1'b0;
    bus.ld_search_addr = '0;
    step(1);

    // Reset state
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_pop_head", 32'(bus.pop_head), 32'd0);
    chk("rst_drained", 32'(drained), 32'd1);
    chk("rst_drain_count", 32'(drain_count), 32'd0);
    chk("rst_ld_match", 32'(bus.ld_match), 32'd0);
    RST = 1'b0;
    step(1);

    // Single store, ack after three request cycles
    expect_wr(16'h0040, 16'hBEEF);
    enq(16'h0040, 16'hBEEF, "t2_pop");
    chk("t2_req", 32'(bus.mem_req), 32'd1);
    chk("t2_addr", 32'(bus.mem_addr), 32'h0040);
    chk("t2_data", 32'(bus.mem_wdata), 32'hBEEF);
    chk("t2_not_drained", 32'(drained), 32'd0);
    step(2);
    chk("t2_addr_held", 32'(bus.mem_addr), 32'h0040);
    chk("t2_data_held", 32'(bus.mem_wdata), 32'hBEEF);
    bus.mem_ack = 1'b1;
    step(1);
    bus.mem_ack = 1'b0;
    chk("t2_req_drop", 32'(bus.mem_req), 32'd0);
    chk("t2_drained", 32'(drained), 32'd1);
    chk("t2_count", 32'(drain_count), 32'd1);

    // Fill to capacity with 0x10..0x15, then release
    for (int i = 0; i < 6; i++) expect_wr(16'h0010 + 16'(i), 16'hA000 + 16'(i));
    sent = 0;
    repeat (8) begin
      bus.head_valid = 1'b1;
      bus.head_addr  = 16'h0010 + 16'(sent);
      bus.head_data  = 16'hA000 + 16'(sent);
      #1;
      if (bus.pop_head) sent++;
      step(1);
    end
    chk("t3_pops_when_full", 32'(sent), 32'd4);
    bus.head_addr = 16'h0014;
    bus.head_data = 16'hA004;
    bus.ld_search_addr = 16'h0012;
    bus.mem_ack = 1'b1;
    #1;
    chk("t3_no_bypass", 32'(bus.pop_head), 32'd0);
    chk("t3_snoop_match", 32'(bus.ld_match), 32'd1);
    chk("t3_snoop_data", 32'(bus.ld_data), 32'hA002);
    w0 = wr_cnt;
    repeat (4) begin
      bus.head_valid = (sent < 6);
      bus.head_addr  = 16'h0010 + 16'(sent);
      bus.head_data  = 16'hA000 + 16'(sent);
      #1;
      if (bus.pop_head) sent++;
      step(1);
    end
    bus.head_valid = 1'b0;
    chk("t3_b2b_writes", 32'(wr_cnt - w0), 32'd4);
    chk("t3_all_popped", 32'(sent), 32'd6);
    drain_all("t3");

    // Snoop returns the youngest match
    expect_wr(16'h0010, 16'h1111);
    expect_wr(16'h0010, 16'h2222);
    bus.ld_search_addr = 16'h0010;
    enq(16'h0010, 16'h1111, "t4_pop0");
    chk("t4_snoop_first", 32'(bus.ld_data), 32'h1111);
    enq(16'h0010, 16'h2222, "t4_pop1");
    chk("t4_match", 32'(bus.ld_match), 32'd1);
    chk("t4_data", 32'(bus.ld_data), 32'h2222);
    bus.ld_search_addr = 16'h0012;
    #1;
    chk("t4_nomatch", 32'(bus.ld_match), 32'd0);
    chk("t4_nomatch_data", 32'(bus.ld_data), 32'd0);
    drain_all("t4");

`ifdef WRITE_COMBINE_EN
    // Same-address merge skips the issuing entry
    expect_wr(16'h0020, 16'h0001);
    expect_wr(16'h0020, 16'h0003);
    enq(16'h0020, 16'h0001, "t5_pop0");
    enq(16'h0020, 16'h0002, "t5_pop1");
    enq(16'h0020, 16'h0003, "t5_pop2");
    bus.ld_search_addr = 16'h0020;
    #1;
    chk("t5_snoop", 32'(bus.ld_data), 32'h0003);
    drain_all("t5");
`endif

    // Reset while issuing discards held entries
    enq(16'h0030, 16'h3000, "t6_pop0");
    enq(16'h0031, 16'h3001, "t6_pop1");
    enq(16'h0032, 16'h3002, "t6_pop2");
    chk("t6_req_before", 32'(bus.mem_req), 32'd1);
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    exp_drain = 0;
    chk("t6_req", 32'(bus.mem_req), 32'd0);
    chk("t6_drained", 32'(drained), 32'd1);
    chk("t6_count", 32'(drain_count), 32'd0);
    w0 = wr_cnt;
    bus.mem_ack = 1'b1;
    step(5);
    bus.mem_ack = 1'b0;
    chk("t6_no_writes", 32'(wr_cnt - w0), 32'd0);
    chk("t6_req_after", 32'(bus.mem_req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
